// File: rtl/fpga_pkg.sv
// Shared definitions for the AXI read arbiter: requester slot indices and FSM state encoding.
package fpga_pkg;

    localparam int ICACHE_IDX = 0;
    localparam int DMISS_IDX  = 1;
    localparam int DUC_IDX    = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/axi_rd_arbiter.sv
// Round-robin AR arbiter with ID-indexed R routing; AR out one cycle after pick, R path combinational.
// AR payload held until m_ar_ready_i; R backpressure passes straight through from the addressed requester.
module axi_rd_arbiter
    import fpga_pkg::*;
#(
    parameter  int NUM_REQ   = 3,
    parameter  int ADDR_W    = 64,
    parameter  int DATA_W    = 512,
    parameter  int ID_W      = 4,
    parameter  int MAX_OUTST = 4,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_ar_valid_i,
    output logic [NUM_REQ-1:0]        req_ar_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0] req_ar_addr_i,
    input  logic [NUM_REQ*ID_W-1:0]   req_ar_id_i,
    input  logic [NUM_REQ*8-1:0]      req_ar_len_i,
    input  logic [NUM_REQ*3-1:0]      req_ar_size_i,
    output logic [NUM_REQ-1:0]        req_r_valid_o,
    input  logic [NUM_REQ-1:0]        req_r_ready_i,
    output logic [DATA_W-1:0]         req_r_data_o,
    output logic [ID_W-1:0]           req_r_id_o,
    output logic [1:0]                req_r_resp_o,
    output logic                      req_r_last_o,
    output logic                      m_ar_valid_o,
    input  logic                      m_ar_ready_i,
    output logic [ADDR_W-1:0]         m_ar_addr_o,
    output logic [ID_W+IDX_W-1:0]     m_ar_id_o,
    output logic [7:0]                m_ar_len_o,
    output logic [2:0]                m_ar_size_o,
    input  logic                      m_r_valid_i,
    output logic                      m_r_ready_o,
    input  logic [DATA_W-1:0]         m_r_data_i,
    input  logic [ID_W+IDX_W-1:0]     m_r_id_i,
    input  logic [1:0]                m_r_resp_i,
    input  logic                      m_r_last_i,
    output logic                      err_o
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q [NUM_REQ];
    logic [CNT_W-1:0]  cnt_d [NUM_REQ];
    logic              err_q, err_d;

    logic [NUM_REQ-1:0] elig;
    logic               ar_hs;
    logic [IDX_W-1:0]   r_idx;
    logic               r_idx_ok;
    logic               r_hs;
    logic               inc_v, dec_v;

    // First eligible index at or after ptr, scanning cyclically.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] e,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && e[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            elig[k] = req_ar_valid_i[k] && (cnt_q[k] < CNT_W'(MAX_OUTST));
        end
    end

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    grant_d = rr_pick(elig, rr_ptr_q);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (ar_hs) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs; payload is muxed live since requesters hold it stable until accepted.
    always_comb begin
        m_ar_valid_o   = (state_q == ISSUE) && !rst_i;
        req_ar_ready_o = '0;
        if (m_ar_valid_o) begin
            req_ar_ready_o[grant_q] = m_ar_ready_i;
        end
        ar_hs       = m_ar_valid_o && m_ar_ready_i;
        m_ar_addr_o = req_ar_addr_i[int'(grant_q)*ADDR_W +: ADDR_W];
        m_ar_id_o   = {grant_q, req_ar_id_i[int'(grant_q)*ID_W +: ID_W]};
        m_ar_len_o  = req_ar_len_i[int'(grant_q)*8 +: 8];
        m_ar_size_o = req_ar_size_i[int'(grant_q)*3 +: 3];
    end

    always_comb begin
        r_idx         = m_r_id_i[ID_W+IDX_W-1 -: IDX_W];
        r_idx_ok      = int'(r_idx) < NUM_REQ;
        req_r_valid_o = '0;
        m_r_ready_o   = 1'b1;
        if (r_idx_ok) begin
            req_r_valid_o[r_idx] = m_r_valid_i;
            m_r_ready_o          = req_r_ready_i[r_idx];
        end
        r_hs = m_r_valid_i && m_r_ready_o;
    end

    assign req_r_data_o = m_r_data_i;
    assign req_r_id_o   = m_r_id_i[ID_W-1:0];
    assign req_r_resp_o = m_r_resp_i;
    assign req_r_last_o = m_r_last_i;

    always_comb begin
        err_d = err_q;
        inc_v = 1'b0;
        dec_v = 1'b0;
        if (r_hs && !r_idx_ok) begin
            err_d = 1'b1;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            cnt_d[k] = cnt_q[k];
            inc_v    = ar_hs && (grant_q == IDX_W'(k));
            dec_v    = r_hs && m_r_last_i && r_idx_ok && (r_idx == IDX_W'(k));
            if (inc_v && !dec_v) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end else if (dec_v && !inc_v) begin
                if (cnt_q[k] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            err_q <= err_d;
            for (int k = 0; k < NUM_REQ; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign err_o = err_q;

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Round-robin arbiter that shares the single AXI4 read-address/read-data channel pair between the core's read requesters: iCache refill, dCache miss-read and dCache uncached read. It sits between the per-requester read ports and the AXI master feeding the atomics processor. The requester index is prepended to the AR ID, and R beats are routed back by that index. A per-requester outstanding-burst counter throttles each requester.

## Interface
Parameters:
- NUM_REQ, 3: number of read requesters (index 0 = iCache, 1 = dCache miss, 2 = dCache uncached).
- ADDR_W, 64: AR address width.
- DATA_W, 512: R data width (matches HPDCACHE_MEM_DATA_WIDTH).
- ID_W, 4: requester-side ID width (matches HPDCACHE_MEM_TID_WIDTH).
- MAX_OUTST, 4: maximum outstanding bursts per requester. Must be at least 1.
- IDX_W, derived as clog2(NUM_REQ): width of the prepended index field.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset. Synchronous, active-high.
- req_ar_valid_i, in, NUM_REQ: per-requester AR valid.
- req_ar_ready_o, out, NUM_REQ: per-requester AR ready.
- req_ar_addr_i, in, NUM_REQ×ADDR_W: per-requester AR address.
- req_ar_id_i, in, NUM_REQ×ID_W: per-requester AR ID.
- req_ar_len_i, in, NUM_REQ×8: per-requester AR burst length.
- req_ar_size_i, in, NUM_REQ×3: per-requester AR beat size.
- req_r_valid_o, out, NUM_REQ: per-requester R valid (one-hot or zero).
- req_r_ready_i, in, NUM_REQ: per-requester R ready.
- req_r_data_o, out, DATA_W: R data, broadcast to all requesters.
- req_r_id_o, out, ID_W: R ID with the index field stripped.
- req_r_resp_o, out, 2: R response, broadcast.
- req_r_last_o, out, 1: R last, broadcast.
- m_ar_valid_o, out, 1: master AR valid.
- m_ar_ready_i, in, 1: master AR ready.
- m_ar_addr_o, out, ADDR_W: master AR address.
- m_ar_id_o, out, ID_W+IDX_W: master AR ID, formed as {index, requester ID}.
- m_ar_len_o, out, 8: master AR burst length.
- m_ar_size_o, out, 3: master AR beat size.
- m_r_valid_i, in, 1: master R valid.
- m_r_ready_o, out, 1: master R ready.
- m_r_data_i, in, DATA_W: master R data.
- m_r_id_i, in, ID_W+IDX_W: master R ID.
- m_r_resp_i, in, 2: master R response.
- m_r_last_i, in, 1: master R last.
- err_o, out, 1: sticky protocol-error flag.

## Operation
State machine:
- The arbiter has two states, IDLE and ISSUE.
- **IDLE.** The eligible set is req_ar_valid_i[k] with cnt[k] < MAX_OUTST.
  - If the eligible set is non-empty, pick the first eligible index at or after rr_ptr, cyclically.
  - Register the pick as grant and go to ISSUE.
- **ISSUE.**
  - m_ar_valid_o = 1.
  - The AR payload is muxed from requester[grant]. Requesters hold the payload stable per AXI, so it is not registered.
  - req_ar_ready_o[grant] = m_ar_ready_i. All other ready bits are 0.
  - On the m_ar handshake: cnt[grant]++, rr_ptr = grant+1 (wraps to 0 when grant = NUM_REQ-1), return to IDLE.

Outstanding counters:
- Width is clog2(MAX_OUTST+1).
- A counter decrements on an R handshake with last = 1 routed to its requester.
- Simultaneous increment and decrement on the same counter leaves it unchanged.
- Decrement at 0 saturates at 0 and sets err_o.

R routing (combinational):
- idx = m_r_id_i[ID_W+IDX_W-1 -: IDX_W].
- If idx < NUM_REQ: req_r_valid_o[idx] = m_r_valid_i and m_r_ready_o = req_r_ready_i[idx].
- If idx ≥ NUM_REQ: all req_r_valid_o are 0, m_r_ready_o = 1 (the beat is drained and dropped), and err_o is set on the handshake.

err_o is cleared only by reset.

## Timing
Reset:
- rst_i sampled high forces: state IDLE, grant 0, rr_ptr 0, all cnt 0, err_o 0.
- Outputs during reset: m_ar_valid_o 0 and all req_ar_ready_o 0.
- Reset asserted mid-burst abandons the transaction. The bench must reset the master side together with the arbiter.

AR path:
- req valid sampled in cycle N (state IDLE) gives m_ar_valid_o high in cycle N+1.
- req_ar_ready_o rises in the cycle m_ar_ready_i is high, with zero added latency.
- Peak throughput is one AR every 2 cycles.
- m_ar_valid_o never drops before its handshake. The grant holds even if the requester deasserts valid, which is a requester protocol violation.

R path:
- Zero latency, purely combinational.
- Concurrent AR and R traffic is fully independent.

## Structure
- Package fpga_pkg holds:
  - the requester index constants ICACHE_IDX, DMISS_IDX and DUC_IDX;
  - the arb_state_t enum (IDLE, ISSUE).
- There are no sub-modules. The round-robin pick is an inline function.

## Test plan
- **Single request.** Reset, then requester 1 issues addr 0x8000_0040, id 3, len 0, with m_ar_ready_i held 1.
  - Required: m_ar_valid_o rises one cycle later with m_ar_id_o = 0x13 (index 1, ID 3 with IDX_W = 2).
  - Required: req_ar_ready_o = 3'b010 for exactly one cycle.
- **Round-robin.** All three requesters are valid continuously.
  - Required: grants follow the order 0, 1, 2, 0, … and each requester gets one AR per 6 cycles.
- **Throttle.** Requester 0 issues 4 ARs with no R returned (MAX_OUTST = 4).
  - Required: a 5th AR from requester 0 is not granted while requesters 1 and 2 are still served.
  - Required: after an R with last = 1 and id 0x0_x, requester 0 is granted again.
- **Simultaneous event.** An R last for requester 2 arrives in the same cycle as an AR handshake for requester 2.
  - Required: cnt[2] is unchanged.
- **Backpressure.** m_ar_ready_i is held 0 for 5 cycles.
  - Required: m_ar_valid_o stays high with a stable payload, and the grant does not move.
  - Separately, for R: m_r_valid_i with id index 2 while req_r_ready_i[2] = 0 gives m_r_ready_o = 0.
- **Error.** An R beat arrives with index 3 while NUM_REQ = 3.
  - Required: the beat is dropped with m_r_ready_o = 1, and err_o goes to 1 and stays set until rst_i.
